// File: rtl/serial_shift_driver.sv
// -----------------------------------------------------------------------------
// serial_shift_driver
//
// Shifts a captured parallel word out over CHANNELS serial lanes that share
// one shift clock (s_clk), one active-low clear (s_clrn) and one latch strobe
// (s_latch). This matches the usual chain of 74HC595-style shift/storage
// registers.
//
// A transfer runs as follows:
//   1. Capture pdata.
//   2. Run DATA_BITS low/high s_clk periods. Each half-period lasts CLK_DIV
//      clk cycles.
//   3. Pulse s_latch for CLK_DIV cycles.
//   4. Pulse done for one cycle.
//
// A clear request does not shift. It drives s_clrn low for CLK_DIV cycles,
// then latches the cleared contents, then pulses done.
//
// Every output comes straight from a flop. Each output flop is loaded from the
// next state, so the outputs line up with the state they describe without a
// combinational path from any input.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   start    level; starts a transfer, sampled only in IDLE
//   clear    level; starts a downstream clear, sampled only in IDLE, beats start
//   pdata    CHANNELS*DATA_BITS parallel data, channel k at [k*DATA_BITS +: DATA_BITS]
//   busy     high whenever not IDLE
//   done     one-cycle pulse at the end of a transfer or clear
//   s_clk    serial shift clock
//   s_clrn   active-low downstream clear (low while in reset)
//   s_latch  storage-register latch strobe
//   sout     one serial data bit per channel
// -----------------------------------------------------------------------------
module serial_shift_driver #(
  parameter int DATA_BITS = 32,
  parameter int CHANNELS  = 1,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clear,
  input  logic [CHANNELS*DATA_BITS-1:0] pdata,
  output logic                          busy,
  output logic                          done,
  output logic                          s_clk,
  output logic                          s_clrn,
  output logic                          s_latch,
  output logic [CHANNELS-1:0]           sout
);

  localparam int                 W        = CHANNELS * DATA_BITS;
  localparam int                 BIT_W    = $clog2(DATA_BITS + 1);
  localparam logic [7:0]         DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    CLEAR,
    LATCH,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [W-1:0]        shreg_q, shreg_d;
  logic [W-1:0]        shreg_adv;
  logic [CHANNELS-1:0] cur_bits;
  logic                phase_end;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                s_clk_q, s_clk_d;
  logic                s_clrn_q, s_clrn_d;
  logic                s_latch_q, s_latch_d;
  logic [CHANNELS-1:0] sout_q, sout_d;

  assign phase_end = (div_cnt_q == DIV_LAST);

  // The shift register after one advance. The vacated end of each channel
  // fills with zero, so the register ends up empty after a full transfer.
  always_comb begin
    shreg_adv = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MSB_FIRST != 0) begin
        shreg_adv[k*DATA_BITS +: DATA_BITS] = {shreg_q[k*DATA_BITS +: DATA_BITS-1], 1'b0};
      end else begin
        shreg_adv[k*DATA_BITS +: DATA_BITS] = {1'b0, shreg_q[k*DATA_BITS+1 +: DATA_BITS-1]};
      end
    end
  end

  // The bit each channel presents next. It is taken from the next-state
  // shift register, so the value captured or advanced at this edge appears
  // on sout in the same cycle that SHIFT_LO begins.
  always_comb begin
    cur_bits = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MSB_FIRST != 0) begin
        cur_bits[k] = shreg_d[k*DATA_BITS + DATA_BITS-1];
      end else begin
        cur_bits[k] = shreg_d[k*DATA_BITS];
      end
    end
  end

  // Next-state logic. Every timed state leaves when the half-period counter
  // reaches CLK_DIV-1. Leaving a state rewinds that counter to zero.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that forgets
    // to assign one then keeps its old value explicitly instead of inferring
    // a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (clear) begin
          state_d = CLEAR;
        end else if (start) begin
          state_d   = SHIFT_LO;
          shreg_d   = pdata;
          bit_cnt_d = '0;
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          div_cnt_d = '0;
          shreg_d   = shreg_adv;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          // This is the last high phase when the old count is DATA_BITS-1.
          state_d   = (bit_cnt_q == BIT_LAST) ? LATCH : SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      CLEAR: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = LATCH;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      LATCH: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      DONE: begin
        // start is not looked at here. A held start is accepted in the next
        // IDLE cycle, so every transfer is followed by at least one idle cycle.
        bit_cnt_d = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Output flops, decoded from the state being entered.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    s_clk_d   = (state_d == SHIFT_HI);
    s_clrn_d  = (state_d != CLEAR);
    s_latch_d = (state_d == LATCH);
    sout_d    = '0;
    unique case (state_d)
      SHIFT_LO:        sout_d = cur_bits;
      SHIFT_HI, LATCH: sout_d = sout_q;   // hold across the rising s_clk edge
      default:         sout_d = '0;
    endcase
  end

  // s_clrn resets low, so the downstream registers clear while rst is held.
  // It comes back high on the first clk edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clk_q   <= 1'b0;
      s_clrn_q  <= 1'b0;
      s_latch_q <= 1'b0;
      sout_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make all flops sample their _d values
      // from the same edge, whatever order they are written in.
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clk_q   <= s_clk_d;
      s_clrn_q  <= s_clrn_d;
      s_latch_q <= s_latch_d;
      sout_q    <= sout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_clk   = s_clk_q;
  assign s_clrn  = s_clrn_q;
  assign s_latch = s_latch_q;
  assign sout    = sout_q;

endmodule

// File: tb/tb_serial_shift_driver.sv
// -----------------------------------------------------------------------------
// tb_serial_shift_driver
//
// Three instances share one clock and one reset:
//   d0  8 bits, 2 channels, CLK_DIV=2, MSB first
//   d1  8 bits, 1 channel,  CLK_DIV=2, LSB first
//   d2  32 bits, 1 channel, CLK_DIV=1, MSB first
//
// Each operation is watched cycle by cycle from the accepting edge. Outputs
// are sampled 1 time unit after each rising clk edge, and the samples are
// reduced to a few figures:
//   - the sout bits seen at each s_clk rise
//   - the number of s_clk toggles
//   - the latch width and position
//   - the done cycle
//   - busy behaviour
// These figures are compared with hand-written table values and with a
// reference model built from the shifting rules.
// -----------------------------------------------------------------------------
module tb_serial_shift_driver;

  localparam int DB  [3] = '{8, 8, 32};
  localparam int CH  [3] = '{2, 1, 1};
  localparam int DIV [3] = '{2, 2, 1};
  localparam int MSB [3] = '{1, 0, 1};

  logic        clk;
  logic        rst;
  logic [2:0]  start_v, clear_v;
  logic [15:0] pdata0;
  logic [7:0]  pdata1;
  logic [31:0] pdata2;
  logic [2:0]  busy_v, done_v, sclk_v, sclrn_v, slatch_v;
  logic [1:0]  sout0;
  logic        sout1, sout2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       sclk;
    logic       clrn;
    logic       latch;
    logic [1:0] sout;
  } obs_t;

  typedef struct {
    logic [31:0] seq0;
    logic [31:0] seq1;
    int          rises;
    int          toggles;
    int          latch_cycles;
    int          latch_pulses;
    int          latch_last;
    int          clrn_low;
    int          done_cyc;
    int          done_pulses;
    int          busy_gaps;
    logic        busy_after;
  } op_res_t;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] data;
    bit          is_clr;
    logic [31:0] exp_seq0;
    logic [31:0] exp_seq1;
    int          exp_done;
    int          exp_toggles;
  } vec_t;

  serial_shift_driver #(.DATA_BITS(8), .CHANNELS(2), .CLK_DIV(2), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .clear(clear_v[0]), .pdata(pdata0),
    .busy(busy_v[0]), .done(done_v[0]), .s_clk(sclk_v[0]), .s_clrn(sclrn_v[0]),
    .s_latch(slatch_v[0]), .sout(sout0)
  );

  serial_shift_driver #(.DATA_BITS(8), .CHANNELS(1), .CLK_DIV(2), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .clear(clear_v[1]), .pdata(pdata1),
    .busy(busy_v[1]), .done(done_v[1]), .s_clk(sclk_v[1]), .s_clrn(sclrn_v[1]),
    .s_latch(slatch_v[1]), .sout(sout1)
  );

  serial_shift_driver #(.DATA_BITS(32), .CHANNELS(1), .CLK_DIV(1), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .clear(clear_v[2]), .pdata(pdata2),
    .busy(busy_v[2]), .done(done_v[2]), .s_clk(sclk_v[2]), .s_clrn(sclrn_v[2]),
    .s_latch(slatch_v[2]), .sout(sout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int i);
    obs_t o;
    o.busy  = busy_v[i];
    o.done  = done_v[i];
    o.sclk  = sclk_v[i];
    o.clrn  = sclrn_v[i];
    o.latch = slatch_v[i];
    o.sout  = (i == 0) ? sout0 : (i == 1) ? {1'b0, sout1} : {1'b0, sout2};
    return o;
  endfunction

  task automatic set_pdata(input int i, input logic [31:0] d);
    case (i)
      0:       pdata0 = d[15:0];
      1:       pdata1 = d[7:0];
      default: pdata2 = d;
    endcase
  endtask

  // Reference: the sout value seen at the j-th s_clk rise of channel k is
  // stored in bit j of the result.
  function automatic logic [31:0] model_seq(input logic [31:0] data, input int i, input int k);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < DB[i]; j++) begin
      s[j] = (MSB[i] != 0) ? data[k*DB[i] + DB[i] - 1 - j] : data[k*DB[i] + j];
    end
    return s;
  endfunction

  // Issue one operation on DUT i and record what the serial side does.
  // Cycle 1 is the cycle right after the accepting edge.
  task automatic run_op(input int i, input logic [31:0] data, input bit is_clr,
                        input bit hold, output op_res_t r);
    obs_t o;
    bit   prev_clk, prev_lat;
    int   cyc, budget;
    r.seq0 = '0; r.seq1 = '0; r.rises = 0; r.toggles = 0;
    r.latch_cycles = 0; r.latch_pulses = 0; r.latch_last = -1;
    r.clrn_low = 0; r.done_cyc = -1; r.done_pulses = 0; r.busy_gaps = 0;
    r.busy_after = 1'b1;
    budget = 2 * DIV[i] * DB[i] + DIV[i] + 20;
    @(negedge clk);
    set_pdata(i, data);
    start_v[i] = 1'b1;
    clear_v[i] = is_clr;
    @(posedge clk); #1;
    if (!hold) start_v[i] = 1'b0;
    clear_v[i] = 1'b0;
    set_pdata(i, ~data);            // later pdata must not reach the lanes
    prev_clk = 1'b0;
    prev_lat = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      o = obs(i);
      if (r.done_cyc < 0 && !o.busy) r.busy_gaps++;
      if (r.done_cyc >= 0 && cyc == r.done_cyc + 1) begin
        r.busy_after = o.busy;
        break;
      end
      if (o.sclk != prev_clk) r.toggles++;
      if (o.sclk && !prev_clk && r.rises < 32) begin
        r.seq0[r.rises] = o.sout[0];
        r.seq1[r.rises] = o.sout[1];
        r.rises++;
      end
      if (o.latch) begin
        r.latch_cycles++;
        r.latch_last = cyc;
        if (!prev_lat) r.latch_pulses++;
      end
      if (!o.clrn) r.clrn_low++;
      if (o.done) begin
        r.done_pulses++;
        if (r.done_cyc < 0) r.done_cyc = cyc;
      end
      prev_clk = o.sclk;
      prev_lat = o.latch;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_op(input string name, input int i, input op_res_t r, input bit is_clr,
                          input logic [31:0] exp_seq0, input logic [31:0] exp_seq1,
                          input int exp_done, input int exp_toggles);
    check({name, " done_cycle"},   r.done_cyc,     exp_done);
    check({name, " done_pulses"},  r.done_pulses,  1);
    check({name, " sclk_toggles"}, r.toggles,      exp_toggles);
    check({name, " latch_cycles"}, r.latch_cycles, DIV[i]);
    check({name, " latch_pulses"}, r.latch_pulses, 1);
    check({name, " latch_last"},   r.latch_last,   exp_done - 1);
    check({name, " clrn_low"},     r.clrn_low,     is_clr ? DIV[i] : 0);
    check({name, " busy_gaps"},    r.busy_gaps,    0);
    check({name, " busy_after"},   r.busy_after,   1'b0);
    if (!is_clr) begin
      check({name, " seq_ch0"}, r.seq0, exp_seq0);
      if (CH[i] == 2) check({name, " seq_ch1"}, r.seq1, exp_seq1);
    end
  endtask

  vec_t    vecs[6];
  op_res_t res;

  initial begin
    logic [31:0] d;
    int          i;
    int          rises, n, dones;
    bit          prev;
    obs_t        o;

    vecs[0] = '{"a5_msb",   0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 32'h0, 35, 16};
    vecs[1] = '{"ff_00",    0, 32'h0000_FF00, 1'b0, 32'h0000_0000, 32'hFF, 35, 16};
    vecs[2] = '{"one_msb",  0, 32'h0000_0001, 1'b0, 32'h0000_0080, 32'h0, 35, 16};
    vecs[3] = '{"one_lsb",  1, 32'h0000_0001, 1'b0, 32'h0000_0001, 32'h0, 35, 16};
    vecs[4] = '{"w32_div1", 2, 32'hC000_0000, 1'b0, 32'h0000_0003, 32'h0, 66, 64};
    vecs[5] = '{"clear",    0, 32'h0000_1234, 1'b1, 32'h0,         32'h0,  5,  0};

    rst = 1'b0; start_v = '0; clear_v = '0;
    pdata0 = '0; pdata1 = '0; pdata2 = '0;
    #1 rst = 1'b1;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      check($sformatf("reset busy d%0d", k),   o.busy,  1'b0);
      check($sformatf("reset done d%0d", k),   o.done,  1'b0);
      check($sformatf("reset sclk d%0d", k),   o.sclk,  1'b0);
      check($sformatf("reset latch d%0d", k),  o.latch, 1'b0);
      check($sformatf("reset clrn d%0d", k),   o.clrn,  1'b0);
      check($sformatf("reset sout d%0d", k),   o.sout,  2'b00);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post-reset clrn d%0d", k), sclrn_v[k], 1'b1);
    end

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].dut, vecs[v].data, vecs[v].is_clr, 1'b0, res);
      check_op(vecs[v].name, vecs[v].dut, res, vecs[v].is_clr, vecs[v].exp_seq0,
               vecs[v].exp_seq1, vecs[v].exp_done, vecs[v].exp_toggles);
    end

    // start held through a whole transfer. There is exactly one transfer,
    // one idle cycle after DONE, and then a fresh acceptance.
    run_op(0, 32'h0000_3C96, 1'b0, 1'b1, res);
    check_op("hold", 0, res, 1'b0, model_seq(32'h3C96, 0, 0), model_seq(32'h3C96, 0, 1),
             2 * 2 * 8 + 2 + 1, 16);
    @(posedge clk); #1;
    check("hold reaccept busy", busy_v[0], 1'b1);
    start_v[0] = 1'b0;
    dones = 0;
    n = 0;
    while (busy_v[0] && n < 60) begin
      if (done_v[0]) dones++;
      @(posedge clk); #1;
      n++;
    end
    check("hold second done count", dones, 1);
    check("hold second busy low", busy_v[0], 1'b0);

    // Reset in the middle of a transfer, after the third s_clk rise.
    @(negedge clk);
    pdata0 = 16'h5A3C;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    rises = 0; n = 0; prev = 1'b0;
    while (rises < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (sclk_v[0] && !prev) rises++;
      prev = sclk_v[0];
    end
    check("abort rises seen", rises, 3);
    #2 rst = 1'b1;
    #1;
    o = obs(0);
    check("abort sclk", o.sclk, 1'b0);
    check("abort latch", o.latch, 1'b0);
    check("abort sout", o.sout, 2'b00);
    check("abort busy", o.busy, 1'b0);
    check("abort done", o.done, 1'b0);
    check("abort clrn", o.clrn, 1'b0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_v[0] || slatch_v[0]) dones++;
    end
    check("abort no done/latch", dones, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("abort clrn release", sclrn_v[0], 1'b1);
    check("abort idle after release", busy_v[0], 1'b0);
    run_op(0, 32'h0000_C35A, 1'b0, 1'b0, res);
    check_op("after_abort", 0, res, 1'b0, model_seq(32'hC35A, 0, 0),
             model_seq(32'hC35A, 0, 1), 35, 16);

    // Random transfers against the reference model.
    for (int t = 0; t < 24; t++) begin
      i = $urandom_range(0, 2);
      d = $urandom;
      run_op(i, d, 1'b0, 1'b0, res);
      check_op($sformatf("rand%0d_d%0d", t, i), i, res, 1'b0, model_seq(d, i, 0),
               model_seq(d, i, 1), 2 * DIV[i] * DB[i] + DIV[i] + 1, 2 * DB[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
